mdu_pipe: RTL



---
 rtl/mdu_pipe.sv | 96 +++++++++
 1 files changed

// File: rtl/mdu_pipe.sv
// mdu_pipe: multi-cycle multiply/divide unit owning HI/LO, with a latency countdown, busy and flush.
// Results are computed at accept and parked in a pending register until the countdown expires.
module mdu_pipe #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             flush_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);
  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  typedef enum logic {IDLE, RUN} state_e;
  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   pend_q, pend_d;
  logic [WIDTH-1:0]     hi_q, hi_d, lo_q, lo_d;
  logic                 done_q, done_d;
  logic                 accept, commit;
  logic [2*WIDTH-1:0]   a_x, b_x, prod;
  logic [WIDTH-1:0]     abs_a, abs_b, div_b, uq, ur, quot, rem;
  logic                 sgn;
  assign accept = start_i && state_q == IDLE && !flush_i && op_i <= 3'd5;
  assign sgn    = !op_i[0];
  // Sign-extended operands make one unsigned multiplier serve MULT and MULTU.
  assign a_x    = {{WIDTH{sgn & a_i[WIDTH-1]}}, a_i};
  assign b_x    = {{WIDTH{sgn & b_i[WIDTH-1]}}, b_i};
  assign prod   = a_x * b_x;
  // Signed divide runs on magnitudes; MIN/-1 falls out as MIN with remainder 0.
  assign abs_a  = (sgn && a_i[WIDTH-1]) ? -a_i : a_i;
  assign abs_b  = (sgn && b_i[WIDTH-1]) ? -b_i : b_i;
  assign div_b  = (b_i == '0) ? WIDTH'(1) : abs_b;
  assign uq     = abs_a / div_b;
  assign ur     = abs_a % div_b;
  assign quot   = (b_i == '0) ? '1 : (sgn && (a_i[WIDTH-1] ^ b_i[WIDTH-1])) ? -uq : uq;
  assign rem    = (b_i == '0) ? a_i : (sgn && a_i[WIDTH-1]) ? -ur : ur;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    commit  = 1'b0;
    if (flush_i) begin
      state_d = IDLE;
      cnt_d   = '0;
      pend_d  = '0;
    end else if (state_q == RUN) begin
      cnt_d = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) begin
        state_d = IDLE;
        commit  = 1'b1;
      end
    end else if (accept && !op_i[2]) begin
      state_d = RUN;
      cnt_d   = op_i[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
      pend_d  = op_i[1] ? {rem, quot} : prod;
    end
  end
  always_comb begin
    hi_d   = hi_q;
    lo_d   = lo_q;
    done_d = commit;
    if (commit) {hi_d, lo_d} = pend_q;
    else if (accept && op_i == 3'd4) hi_d = a_i;
    else if (accept && op_i == 3'd5) lo_d = a_i;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pend_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end
  assign busy_o = state_q == RUN;
  assign done_o = done_q;
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;
endmodule
